// File: rtl/led_controller.sv
// Multi-channel status LED driver: each channel is OFF, ON, BLINK, PWM-dim or
// ALIVE (a slice of a free-running counter), selected through a one-cycle config port.
module led_controller #(
    parameter int NUM_LEDS   = 9,
    parameter int CNT_W      = 32,
    parameter int PRESCALE   = 1000,
    parameter int PWM_W      = 8,
    parameter int ACTIVE_LOW = 0,
    parameter int IDX_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk_u59,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [2:0]          cfg_mode,
    input  logic [PWM_W-1:0]    cfg_param,
    output logic                cfg_err,
    output logic                tick,
    output logic [NUM_LEDS-1:0] leds
);

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_PWM   = 3'd3,
        MODE_ALIVE = 3'd4
    } mode_t;

    localparam int   PRE_W = $clog2(PRESCALE);
    localparam logic POL   = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]    alive_cnt_reg;
    logic [PRE_W-1:0]    prescale_reg;
    logic                tick_reg;
    logic [PWM_W-1:0]    pwm_phase_reg;
    logic                cfg_err_reg;
    logic [NUM_LEDS-1:0] leds_reg;
    logic [NUM_LEDS-1:0] lit;
    logic                cfg_valid;
    logic                cfg_hit;

    assign cfg_valid = ({1'b0, cfg_idx} < (IDX_W + 1)'(NUM_LEDS));
    assign cfg_hit   = cfg_we && cfg_valid;

    always_ff @(posedge clk_u59 or negedge rst_n) begin
        if (!rst_n) begin
            alive_cnt_reg <= '0;
            prescale_reg  <= '0;
            tick_reg      <= 1'b0;
            pwm_phase_reg <= '0;
            cfg_err_reg   <= 1'b0;
            leds_reg      <= {NUM_LEDS{POL}};
        end else begin
            alive_cnt_reg <= alive_cnt_reg + CNT_W'(1);
            if (prescale_reg == PRE_W'(PRESCALE - 1)) begin
                prescale_reg <= '0;
            end else begin
                prescale_reg <= prescale_reg + PRE_W'(1);
            end
            tick_reg <= (prescale_reg == PRE_W'(PRESCALE - 1));
            if (tick_reg) begin
                pwm_phase_reg <= pwm_phase_reg + PWM_W'(1);
            end
            cfg_err_reg <= cfg_we && !cfg_valid;
            leds_reg    <= lit ^ {NUM_LEDS{POL}};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
            logic [2:0]       mode_reg;
            logic [PWM_W-1:0] param_reg;
            logic [PWM_W-1:0] blink_cnt_reg;
            logic             blink_state_reg;
            logic             wr_sel;
            logic             lit_ch;

            assign wr_sel = cfg_hit && (cfg_idx == IDX_W'(gi));

            // A write on a tick cycle clears the blink phase instead of advancing it.
            always_ff @(posedge clk_u59 or negedge rst_n) begin
                if (!rst_n) begin
                    mode_reg        <= MODE_ALIVE;
                    param_reg       <= '0;
                    blink_cnt_reg   <= '0;
                    blink_state_reg <= 1'b0;
                end else if (wr_sel) begin
                    mode_reg        <= cfg_mode;
                    param_reg       <= cfg_param;
                    blink_cnt_reg   <= '0;
                    blink_state_reg <= 1'b0;
                end else if (tick_reg && mode_reg == MODE_BLINK) begin
                    if (blink_cnt_reg == param_reg) begin
                        blink_cnt_reg   <= '0;
                        blink_state_reg <= ~blink_state_reg;
                    end else begin
                        blink_cnt_reg <= blink_cnt_reg + PWM_W'(1);
                    end
                end
            end

            always_comb begin
                lit_ch = 1'b0;
                case (mode_reg)
                    MODE_ON:    lit_ch = 1'b1;
                    MODE_BLINK: lit_ch = blink_state_reg;
                    MODE_PWM:   lit_ch = (pwm_phase_reg < param_reg);
                    MODE_ALIVE: lit_ch = alive_cnt_reg[CNT_W-NUM_LEDS+gi];
                    default:    lit_ch = 1'b0;
                endcase
            end

            assign lit[gi] = lit_ch;
        end
    endgenerate

    // Low-order counter bits only serve as a divider for the displayed slice.
    logic unused_alive_bits;
    assign unused_alive_bits = &{1'b0, alive_cnt_reg};

    assign cfg_err = cfg_err_reg;
    assign tick    = tick_reg;
    assign leds    = leds_reg;

endmodule

// File: tb/tb_led_controller.sv
// Directed bench for led_controller: one active-high and one active-low instance
// sharing stimulus, with hand-computed expected pin levels.
module tb_led_controller;

    localparam int NUM_LEDS = 9;
    localparam int CNT_W    = 12;
    localparam int PRESCALE = 4;
    localparam int PWM_W    = 4;
    localparam int IDX_W    = 4;

    logic                clk_u59 = 1'b0;
    logic                rst_n;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [2:0]          cfg_mode;
    logic [PWM_W-1:0]    cfg_param;
    logic                cfg_err, cfg_err_al;
    logic                tick, tick_al;
    logic [NUM_LEDS-1:0] leds, leds_al;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk_u59 = ~clk_u59;

    led_controller #(
        .NUM_LEDS(NUM_LEDS), .CNT_W(CNT_W), .PRESCALE(PRESCALE),
        .PWM_W(PWM_W), .ACTIVE_LOW(0), .IDX_W(IDX_W)
    ) dut (
        .clk_u59(clk_u59), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_mode(cfg_mode), .cfg_param(cfg_param), .cfg_err(cfg_err),
        .tick(tick), .leds(leds)
    );

    led_controller #(
        .NUM_LEDS(NUM_LEDS), .CNT_W(CNT_W), .PRESCALE(PRESCALE),
        .PWM_W(PWM_W), .ACTIVE_LOW(1), .IDX_W(IDX_W)
    ) dut_al (
        .clk_u59(clk_u59), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_mode(cfg_mode), .cfg_param(cfg_param), .cfg_err(cfg_err_al),
        .tick(tick_al), .leds(leds_al)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk_u59);
        cyc++;
    endtask

    task automatic cfg_write(input int idx, input int mode, input int param);
        cfg_we    = 1'b1;
        cfg_idx   = IDX_W'(idx);
        cfg_mode  = 3'(mode);
        cfg_param = PWM_W'(param);
        step();
        cfg_we    = 1'b0;
    endtask

    // Pin of an ALIVE channel after `cyc` edges: counter value of the previous cycle.
    function automatic logic alive_bit(input int i);
        int a;
        a = (cyc - 1) & ((1 << CNT_W) - 1);
        return 1'((a >> (CNT_W - NUM_LEDS + i)) & 1);
    endfunction

    initial begin
        int n, hi, lo, lit_cnt;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_mode = '0; cfg_param = '0;
        repeat (5) step();
        check_eq("rst_leds",    32'(leds),    32'h000);
        check_eq("rst_leds_al", 32'(leds_al), 32'h1FF);
        check_eq("rst_tick",    32'(tick),    32'd0);
        check_eq("rst_err",     32'(cfg_err), 32'd0);

        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            check_eq("tick_period", 32'(tick), 32'(cyc % PRESCALE == 0));
            if (k == 8) check_eq("alive_cnt7", 32'(leds), 32'h000);
            if (k == 9) check_eq("alive_cnt8", 32'(leds), 32'h001);
        end
        while (cyc < 4096) step();
        check_eq("alive_pre_wrap",    32'(leds),    32'h1FF);
        check_eq("alive_pre_wrap_al", 32'(leds_al), 32'h000);
        step();
        check_eq("alive_wrap", 32'(leds), 32'h000);

        // BLINK, param 1: 8 clocks lit, 8 clocks dark, starting dark
        cfg_write(2, 2, 1);
        step();
        check_eq("blink_start_dark", 32'(leds[2]), 32'd0);
        check_eq("alive_other",      32'(leds[8]), 32'(alive_bit(8)));
        n = 0;
        while (leds[2] !== 1'b1 && n < 20) begin step(); n++; end
        check_eq("blink_rise_seen", 32'(n < 20), 32'd1);
        hi = 0;
        while (leds[2] === 1'b1 && hi < 20) begin hi++; step(); end
        check_eq("blink_high_len", 32'(hi), 32'd8);
        lo = 0;
        while (leds[2] === 1'b0 && lo < 20) begin lo++; step(); end
        check_eq("blink_low_len", 32'(lo), 32'd8);

        // PWM duty 4/16, 0/16 and 15/16 over 64 clocks
        cfg_write(0, 3, 4);
        step();
        lit_cnt = 0;
        for (int i = 0; i < 64; i++) begin step(); lit_cnt += int'(leds[0]); end
        check_eq("pwm_duty4", 32'(lit_cnt), 32'd16);
        cfg_write(0, 3, 0);
        step();
        lit_cnt = 0;
        for (int i = 0; i < 64; i++) begin step(); lit_cnt += int'(leds[0]); end
        check_eq("pwm_duty0", 32'(lit_cnt), 32'd0);
        cfg_write(0, 3, 15);
        step();
        lit_cnt = 0;
        for (int i = 0; i < 64; i++) begin step(); lit_cnt += int'(leds[0]); end
        check_eq("pwm_duty15", 32'(lit_cnt), 32'd60);

        // ON / OFF / reserved with both polarities
        cfg_write(1, 1, 0); step();
        check_eq("on_al",  32'(leds_al[1]), 32'd0);
        check_eq("on_ah",  32'(leds[1]),    32'd1);
        cfg_write(1, 0, 0); step();
        check_eq("off_al", 32'(leds_al[1]), 32'd1);
        cfg_write(1, 1, 0); step();
        check_eq("on2_al", 32'(leds_al[1]), 32'd0);
        cfg_write(1, 6, 0); step();
        check_eq("rsvd_al", 32'(leds_al[1]), 32'd1);
        check_eq("rsvd_ah", 32'(leds[1]),    32'd0);

        // Out-of-range index: one-cycle error, nothing changes
        cfg_write(1, 1, 0); step();
        check_eq("err_idle", 32'(cfg_err), 32'd0);
        cfg_write(12, 0, 0);
        check_eq("err_pulse", 32'(cfg_err), 32'd1);
        step();
        check_eq("err_clear",    32'(cfg_err),    32'd0);
        check_eq("bad_idx_ch1",  32'(leds[1]),    32'd1);
        check_eq("bad_idx_ch1a", 32'(leds_al[1]), 32'd0);
        check_eq("bad_idx_ch4",  32'(leds[4]),    32'(alive_bit(4)));

        // Write landing on a tick cycle: clear wins, no toggle
        while (cyc % PRESCALE != 1) step();
        cfg_write(3, 2, 0);
        step(); step();
        check_eq("tick_at_collision", 32'(tick), 32'd1);
        cfg_write(3, 2, 0);
        for (int s = 1; s <= 5; s++) begin
            step();
            check_eq("collision_blink", 32'(leds[3]), 32'(s == 5));
        end

        // Asynchronous reset mid-blink
        check_eq("pre_reset_ch1", 32'(leds[1]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_leds",    32'(leds),    32'h000);
        check_eq("async_rst_leds_al", 32'(leds_al), 32'h1FF);
        check_eq("async_rst_tick",    32'(tick),    32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_controller.md
Name: led_controller

Overview:
Parametrised multi-channel LED driver for the board status LEDs, clocked from clk_u59. It is the successor to the free-running alive-count LED block. Each channel can be set independently to off, on, blink, PWM-dim or alive-count mode through a simple single-cycle config write port. The reset default is alive mode on every channel, which reproduces the original heartbeat pattern, so existing bring-up behaviour is kept.

Parameters:
NUM_LEDS, 9, number of LED channels (1..32)
CNT_W, 32, alive counter width; must be >= NUM_LEDS
PRESCALE, 1000, clk_u59 cycles per tick (>= 2)
PWM_W, 8, width of the PWM phase, duty and blink-period fields
ACTIVE_LOW, 0, 1 = invert the pin level (LED lit when pin is 0)

Ports:
clk_u59  in  1  sole clock
rst_n  in  1  reset; asynchronous assert, active-low
cfg_we  in  1  config write strobe, one cycle
cfg_idx  in  IDX_W=max(1,$clog2(NUM_LEDS))  target channel
cfg_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 ALIVE, 5-7 reserved
cfg_param  in  PWM_W  PWM duty, or blink half-period in ticks
cfg_err  out  1  one-cycle pulse when a write is rejected
tick  out  1  one-cycle pulse, once every PRESCALE clocks
leds  out  NUM_LEDS  LED pins, registered

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, all of the following hold:
  - alive_cnt, prescaler, pwm_phase, blink counters and blink states are 0.
  - Every mode is ALIVE (4) and every param is 0.
  - cfg_err=0 and tick=0.
  - leds equals the off level: 0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1.
- Reset can assert at any time and takes effect immediately. A write in the same cycle is lost.
- alive_cnt (CNT_W bits) increments every clock and wraps from 2^CNT_W-1 to 0.
- Prescaler counts 0..PRESCALE-1 and wraps.
  - tick=1 (registered) in the cycle after the prescaler reaches PRESCALE-1.
  - The first tick appears PRESCALE cycles after reset release.
- pwm_phase (PWM_W bits) increments on each tick and wraps.
- Per-channel lit value, before polarity:
  - OFF: 0.
  - ON: 1.
  - BLINK: output is blink_state[i].
    - blink_cnt[i] increments on each tick.
    - On the tick where blink_cnt[i]==param[i], blink_state[i] toggles and blink_cnt[i] clears.
    - Half-period = param+1 ticks; param=0 toggles every tick.
  - PWM: lit = (pwm_phase < param[i]).
    - param=0 is always dark.
    - param=2^PWM_W-1 is lit 255/256 for PWM_W=8.
  - ALIVE: lit = alive_cnt[CNT_W-NUM_LEDS+i].
  - Reserved modes 5-7: the write is accepted, the mode is stored as given, and the channel behaves as OFF.
- Polarity: pin = lit XOR ACTIVE_LOW.
- Config writes:
  - A write with cfg_we=1 and cfg_idx < NUM_LEDS updates mode[idx] and param[idx] on that edge.
  - The same edge clears blink_cnt[idx] and blink_state[idx].
  - If a tick occurs in the same cycle, the write's clear wins for that channel. Other channels still advance normally.
  - A write with cfg_idx >= NUM_LEDS changes no state and gives cfg_err=1 for exactly the next cycle.
  - Back-to-back writes, one per cycle, are all honoured. A later write to the same channel overrides an earlier one.
- Latency:
  - A write sampled at edge N is reflected on leds after edge N+1.
  - leds is registered one clock after the internal state for all modes, including ALIVE: leds shows alive_cnt of the previous cycle.
- There is no back-pressure. The config port is always ready.

Test Plan:
- Reset, with CNT_W=12, NUM_LEDS=9: hold rst_n=0 for 5 clocks, then release.
  - During reset: leds=0 and tick=0.
  - After 8 clocks: leds[0]=1, because alive_cnt bit 3 is set at count 8. That output is registered, so check the 1-cycle offset.
  - At the 2^12 wrap: leds returns to 0.
- Periodic modes, with PRESCALE=4, PWM_W=4:
  - BLINK: write idx 2, mode 2, param 1. leds[2] toggles every 2 ticks (8 clocks), starting dark. Other channels stay in ALIVE.
  - PWM: write idx 0, mode 3, param 4. Over 16 ticks (64 clocks), leds[0] is lit for exactly 16 clocks, in the first 4 ticks of each phase.
- ON/OFF and polarity, with ACTIVE_LOW=1:
  - Write idx 1 mode 1: leds[1]=0 two edges after the write.
  - Write idx 1 mode 0: leds[1]=1.
  - Write idx 1 mode 6: leds[1]=1 (reserved behaves as OFF).
- Invalid index: write idx 12 with NUM_LEDS=9.
  - cfg_err is high for exactly 1 cycle.
  - All modes are unchanged and leds are undisturbed.
- Write/tick collision and mid-operation reset:
  - Channel in BLINK, param 0. Issue a write in the same cycle as a tick: blink_state is 0 afterwards, with no toggle.
  - Assert rst_n mid-blink: leds goes to the off level asynchronously, before the next clock edge.
